// File: rtl/permutation_lane_scheduler.sv
// permutation_lane_scheduler
// Distributes incoming bots round-robin over NUM_LANES permutation lanes.
// Each lane walks a 42-step (permut6, permut7) series from (5,6) down to (0,0)
// and can pick up a fresh bot on its last step so back-to-back series have no
// bubble. seriesCount accumulates finished series and saturates.

module permutation_lane_scheduler #(
  parameter int NUM_LANES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [127:0]               inBot,
  input  logic                       inBotValid,
  output logic                       inBotReady,
  input  logic [NUM_LANES-1:0]       slowDown,
  output logic [128*NUM_LANES-1:0]   laneBots,
  output logic [NUM_LANES-1:0]       laneValid,
  output logic [3*NUM_LANES-1:0]     lanePermut6,
  output logic [3*NUM_LANES-1:0]     lanePermut7,
  output logic [NUM_LANES-1:0]       laneSeriesFinished,
  output logic [31:0]                seriesCount
);

  typedef enum logic {
    LANE_IDLE      = 1'b0,
    LANE_PERMUTING = 1'b1
  } lane_state_e;

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [127:0]         bot_q   [NUM_LANES];
  logic [127:0]         bot_d   [NUM_LANES];
  logic [2:0]           p6_q    [NUM_LANES];
  logic [2:0]           p6_d    [NUM_LANES];
  logic [2:0]           p7_q    [NUM_LANES];
  logic [2:0]           p7_d    [NUM_LANES];
  logic [NUM_LANES-1:0] fin_q;
  logic [NUM_LANES-1:0] fin_d;
  logic [2:0]           rr_q;
  logic [2:0]           rr_d;
  logic [31:0]          cnt_q;
  logic [31:0]          cnt_d;

  logic [NUM_LANES-1:0] want_s;
  logic [NUM_LANES-1:0] elig_s;
  logic [NUM_LANES-1:0] grant_s;
  logic                 xfer_s;

  // Number of lanes that pulsed finished in one cycle.
  function automatic logic [3:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Add with saturation at all-ones so the counter never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {29'd0, b};
    if (s[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return s[31:0];
    end
  endfunction

  // A lane wants a bot when idle or on its final (0,0) step; slowDown masks it.
  always_comb begin
    want_s = '0;
    elig_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      want_s[i] = (state_q[i] == LANE_IDLE) || ((p6_q[i] == 3'd0) && (p7_q[i] == 3'd0));
      elig_s[i] = want_s[i] & ~slowDown[i];
    end
    inBotReady = |elig_s;
    xfer_s     = inBotValid & (|elig_s);
  end

  // Round-robin grant: first eligible lane at or after rr_q, with wrap.
  always_comb begin
    logic found;
    logic hit;
    found   = 1'b0;
    hit     = 1'b0;
    grant_s = '0;
    rr_d    = rr_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        hit        = !found && elig_s[i] && (i == ((int'(rr_q) + k) % NUM_LANES));
        grant_s[i] = grant_s[i] | (hit & xfer_s);
        rr_d       = (hit && xfer_s) ? 3'((i + 1) % NUM_LANES) : rr_d;
        found      = found | hit;
      end
    end
  end

  // Per-lane series stepping: load on grant, count down, go idle after (0,0).
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      bot_d[i]   = bot_q[i];
      p6_d[i]    = p6_q[i];
      p7_d[i]    = p7_q[i];
      if (grant_s[i]) begin
        state_d[i] = LANE_PERMUTING;
        bot_d[i]   = inBot;
        p6_d[i]    = 3'd5;
        p7_d[i]    = 3'd6;
      end else begin
        case (state_q[i])
          LANE_PERMUTING: begin
            if ((p6_q[i] == 3'd0) && (p7_q[i] == 3'd0)) begin
              state_d[i] = LANE_IDLE;
            end else if (p7_q[i] == 3'd0) begin
              p7_d[i] = 3'd6;
              p6_d[i] = p6_q[i] - 3'd1;
            end else begin
              p7_d[i] = p7_q[i] - 3'd1;
            end
          end
          LANE_IDLE: begin
            state_d[i] = LANE_IDLE;
          end
          default: begin
            state_d[i] = LANE_IDLE;
          end
        endcase
      end
      fin_d[i] = (state_d[i] == LANE_PERMUTING) && (p6_d[i] == 3'd0) && (p7_d[i] == 3'd0);
    end
    cnt_d = sat_add(cnt_q, popcount(fin_q));
  end

  // State registers with asynchronous reset abandoning any series.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= LANE_IDLE;
        bot_q[i]   <= 128'd0;
        p6_q[i]    <= 3'd0;
        p7_q[i]    <= 3'd0;
      end
      fin_q <= '0;
      rr_q  <= 3'd0;
      cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        bot_q[i]   <= bot_d[i];
        p6_q[i]    <= p6_d[i];
        p7_q[i]    <= p7_d[i];
      end
      fin_q <= fin_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  // Flatten the per-lane registers onto the output buses.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      laneBots[128*i +: 128] = bot_q[i];
      lanePermut6[3*i +: 3]  = p6_q[i];
      lanePermut7[3*i +: 3]  = p7_q[i];
      laneValid[i]           = (state_q[i] == LANE_PERMUTING);
    end
    laneSeriesFinished = fin_q;
    seriesCount        = cnt_q;
  end

endmodule
